// File: rtl/fir_stereo_serial_mac_pkg.sv
// Shared types, coefficient tables and helpers
// for the stereo serial-MAC FIR filter.
package audio_fir_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_COEF_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        ROUND
    } fir_state_e;

    // Windowed low-pass, unity gain is 2^(COEF_W-1)
    localparam logic signed [DEF_COEF_W-1:0] LP_TAB [32] = '{
        -18'sd64,   -18'sd128,  -18'sd192,  -18'sd192,
        -18'sd64,   18'sd256,   18'sd768,   18'sd1408,
        18'sd2048,  18'sd2560,  18'sd3584,  18'sd5120,
        18'sd7168,  18'sd9216,  18'sd11264, 18'sd12800,
        18'sd12800, 18'sd11264, 18'sd9216,  18'sd7168,
        18'sd5120,  18'sd3584,  18'sd2560,  18'sd2048,
        18'sd1408,  18'sd768,   18'sd256,   -18'sd64,
        -18'sd192,  -18'sd192,  -18'sd128,  -18'sd64
    };

    function automatic logic signed [DEF_COEF_W-1:0] coef(
        input int sel,
        input int k
    );
        logic signed [DEF_COEF_W-1:0] c;
        c = '0;
        case (sel)
            0: if (k >= 0 && k < 32) c = LP_TAB[k[4:0]];
            1: if (k >= 0 && k < 4) c = 18'sh08000;
            2: c = 18'sh10000;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fir_stereo_serial_mac_if.sv
// Sample-pair strobe bus between the I2S
// deserializer, the FIR and the serializer.
interface fir_stereo_serial_mac_if #(
    parameter int DATA_W = audio_fir_pkg::DEF_DATA_W
);
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data_left;
    logic [DATA_W-1:0] i_data_right;
    logic              o_data_valid;
    logic [DATA_W-1:0] o_data_left;
    logic [DATA_W-1:0] o_data_right;
    logic              o_busy;
    logic              o_overrun;

    modport master (
        output i_data_valid, i_data_left, i_data_right,
        input  o_data_valid, o_data_left, o_data_right,
        input  o_busy, o_overrun
    );

    modport slave (
        input  i_data_valid, i_data_left, i_data_right,
        output o_data_valid, o_data_left, o_data_right,
        output o_busy, o_overrun
    );
endinterface

// File: rtl/fir_stereo_serial_mac_channel.sv
// One channel: circular sample buffer, registered
// multiplier, accumulator and round/saturate.
module fir_mac_channel
    import audio_fir_pkg::*;
#(
    parameter int TAPS   = 32,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int AW     = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wp,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]            rd_idx,
    input  logic signed [COEF_W-1:0] coef_k,
    input  logic                     mac_en,
    input  logic                     clr,
    input  logic                     round_en,
    output logic signed [DATA_W-1:0] y
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + AW;

    logic signed [DATA_W-1:0] buf_q [TAPS];
    logic signed [DATA_W-1:0] buf_d [TAPS];
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_v_q, prod_v_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  rnd, shr;
    logic signed [DATA_W-1:0] y_q, y_d;

    always_comb begin
        buf_d = buf_q;
        if (wr_en) buf_d[wp] = wr_data;
        prod_v_d = mac_en;
        prod_d   = mac_en
                 ? PROD_W'(buf_q[rd_idx]) * PROD_W'(coef_k)
                 : prod_q;
        acc_d = acc_q;
        if (clr) acc_d = '0;
        else if (prod_v_q) acc_d = acc_q + ACC_W'(prod_q);
        // round half up, then drop the Q1.(COEF_W-1) fraction
        rnd = acc_q + (ACC_W'(1) <<< (COEF_W - 2));
        shr = rnd >>> (COEF_W - 1);
        y_d = round_en
            ? DATA_W'(saturate(64'(shr), DATA_W))
            : y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '{default: '0};
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            y_q      <= '0;
        end else begin
            buf_q    <= buf_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
        end
    end

    assign y = y_q;
endmodule

// File: rtl/fir_stereo_serial_mac.sv
// Stereo FIR: shared sequencer driving two
// lockstep serial-MAC channels.
module fir_stereo_serial_mac
    import audio_fir_pkg::*;
#(
    parameter int TAPS     = 32,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int COEF_W   = DEF_COEF_W,
    parameter int COEF_SET = 0
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    fir_stereo_serial_mac_if.slave  bus
);
    localparam int AW = $clog2(TAPS);

    fir_state_e  state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic [AW-1:0] wp_q, wp_d;
    logic dcnt_q, dcnt_d;
    logic busy_q, busy_d;
    logic valid_q, valid_d;
    logic ovr_q, ovr_d;
    logic accept, clr, mac_en, round_en;
    logic [AW-1:0] rd_idx;
    logic signed [COEF_W-1:0] coef_k;
    logic signed [DATA_W-1:0] y_l, y_r;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wp_d     = wp_q;
        dcnt_d   = dcnt_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        accept   = 1'b0;
        clr      = 1'b0;
        mac_en   = 1'b0;
        round_en = 1'b0;
        // only IDLE accepts; any other strobe is an overrun
        ovr_d = ovr_q
              | (bus.i_data_valid && state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (bus.i_data_valid) begin
                    accept  = 1'b1;
                    clr     = 1'b1;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                k_d    = k_q + 1'b1;
                if (k_q == AW'(TAPS - 1)) begin
                    dcnt_d  = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_d = 1'b1;
                if (dcnt_q) state_d = ROUND;
            end
            ROUND: begin
                round_en = 1'b1;
                valid_d  = 1'b1;
                wp_d     = wp_q + 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            wp_q    <= '0;
            dcnt_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wp_q    <= wp_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd_idx = wp_q - k_q;
    assign coef_k = COEF_W'(coef(COEF_SET, int'(k_q)));

    fir_mac_channel #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)
    ) u_left (
        .clk(i_clock), .rst_n(i_reset_n),
        .wr_en(accept), .wp(wp_q),
        .wr_data(bus.i_data_left),
        .rd_idx(rd_idx), .coef_k(coef_k),
        .mac_en(mac_en), .clr(clr),
        .round_en(round_en), .y(y_l)
    );

    fir_mac_channel #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)
    ) u_right (
        .clk(i_clock), .rst_n(i_reset_n),
        .wr_en(accept), .wp(wp_q),
        .wr_data(bus.i_data_right),
        .rd_idx(rd_idx), .coef_k(coef_k),
        .mac_en(mac_en), .clr(clr),
        .round_en(round_en), .y(y_r)
    );

    assign bus.o_data_valid = valid_q;
    assign bus.o_data_left  = y_l;
    assign bus.o_data_right = y_r;
    assign bus.o_busy       = busy_q;
    assign bus.o_overrun    = ovr_q;
endmodule

// File: tb/tb_fir_stereo_serial_mac.sv
// Scoreboard bench: three filters (one per table)
// share one stimulus stream against a plain FIR model.
module tb_fir_stereo_serial_mac;
    import audio_fir_pkg::*;

    localparam int TAPS = 32;
    localparam int LAT  = TAPS + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vld = 1'b0;
    logic [23:0] dl = '0;
    logic [23:0] dr = '0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_stereo_serial_mac_if bus0 ();
    fir_stereo_serial_mac_if bus1 ();
    fir_stereo_serial_mac_if bus2 ();

    assign bus0.i_data_valid = vld;
    assign bus0.i_data_left  = dl;
    assign bus0.i_data_right = dr;
    assign bus1.i_data_valid = vld;
    assign bus1.i_data_left  = dl;
    assign bus1.i_data_right = dr;
    assign bus2.i_data_valid = vld;
    assign bus2.i_data_left  = dl;
    assign bus2.i_data_right = dr;

    fir_stereo_serial_mac #(.TAPS(TAPS), .DATA_W(24),
        .COEF_W(18), .COEF_SET(0)) u0 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus0.slave));
    fir_stereo_serial_mac #(.TAPS(TAPS), .DATA_W(24),
        .COEF_W(18), .COEF_SET(1)) u1 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus1.slave));
    fir_stereo_serial_mac #(.TAPS(TAPS), .DATA_W(24),
        .COEF_W(18), .COEF_SET(2)) u2 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus2.slave));

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          t;
    } exp_t;

    exp_t   sb [3][$];
    int     n_vec = 0;
    int     n_bad = 0;
    longint hl [TAPS];
    longint hr [TAPS];
    int     t_last = -1000;
    int     t_acc = -1000;
    bit     ovr_exp = 1'b0;

    function automatic longint cf(input int s, input int k);
        if (s == 0) return longint'(coef(0, k));
        if (s == 1) return (k < 4) ? 64'sd32768 : 64'sd0;
        return 64'sd65536;
    endfunction

    // y = sat(round(sum coef[k] * x[n-k] / 2^17))
    function automatic logic [23:0] fir_ref(input int s, input bit rt);
        longint acc;
        longint y;
        acc = 0;
        for (int k = 0; k < TAPS; k++)
            acc += cf(s, k) * (rt ? hr[k] : hl[k]);
        y = (acc + 65536) >>> 17;
        if (y > 8388607) y = 8388607;
        if (y < -8388608) y = -8388608;
        return y[23:0];
    endfunction

    function automatic logic [48:0] outs(input int i);
        case (i)
            0: return {bus0.o_data_valid, bus0.o_data_left, bus0.o_data_right};
            1: return {bus1.o_data_valid, bus1.o_data_left, bus1.o_data_right};
            default: return {bus2.o_data_valid, bus2.o_data_left, bus2.o_data_right};
        endcase
    endfunction

    function automatic logic [1:0] stat(input int i);
        case (i)
            0: return {bus0.o_busy, bus0.o_overrun};
            1: return {bus1.o_busy, bus1.o_overrun};
            default: return {bus2.o_busy, bus2.o_overrun};
        endcase
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < TAPS; k++) begin
            hl[k] = 0;
            hr[k] = 0;
        end
    endtask

    // sp: minimum cycles since the previous strobe
    task automatic send(input int sp, input logic [23:0] l, input logic [23:0] r);
        bit   busy_e;
        exp_t e;
        @(negedge clk);
        while (cyc - t_last < sp) @(negedge clk);
        t_last = cyc;
        busy_e = (cyc - t_acc) <= LAT - 1;
        for (int i = 0; i < 3; i++)
            cmp($sformatf("busy_ovr%0d@%0d", i, cyc), stat(i), {busy_e, ovr_exp});
        if (!busy_e) begin
            for (int k = TAPS - 1; k > 0; k--) begin
                hl[k] = hl[k-1];
                hr[k] = hr[k-1];
            end
            hl[0] = longint'($signed(l));
            hr[0] = longint'($signed(r));
            for (int s = 0; s < 3; s++) begin
                e.l = fir_ref(s, 1'b0);
                e.r = fir_ref(s, 1'b1);
                e.t = cyc;
                sb[s].push_back(e);
            end
            t_acc = cyc;
        end else begin
            ovr_exp = 1'b1;
        end
        vld = 1'b1;
        dl  = l;
        dr  = r;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic mon(input int i);
        logic [48:0] o;
        exp_t e;
        o = outs(i);
        if (o[48]) begin
            n_vec++;
            if (sb[i].size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid%0d@%0d: got %h want none", i, cyc, o[47:0]);
            end else begin
                e = sb[i].pop_front();
                if (o[47:24] !== e.l || o[23:0] !== e.r || cyc - e.t != LAT) begin
                    n_bad++;
                    $display("FAIL out%0d@%0d: got L=%h R=%h lat=%0d want L=%h R=%h lat=%0d",
                             i, cyc, o[47:24], o[23:0], cyc - e.t, e.l, e.r, LAT);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) mon(i);
        end
    end

    initial begin
        clear_model();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("rst_out%0d", i), outs(i), 0);
            cmp($sformatf("rst_stat%0d", i), stat(i), 0);
        end
        rst_n = 1'b1;

        // step on left
        for (int n = 0; n < 6; n++) send(40, 24'h100000, 24'h000000);
        // full-scale opposite polarities
        for (int n = 0; n < 32; n++) send(37, 24'h7FFFFF, 24'h800000);
        // impulse after a clean history, long run wraps wp
        for (int n = 0; n < 32; n++) send(36, 24'h000000, 24'h000000);
        send(36, 24'h400000, 24'h000000);
        for (int n = 0; n < 69; n++) send(36, 24'h000000, 24'h000000);

        // overruns: mid-MAC and in the ROUND cycle
        send(40, 24'h200000, 24'h0F0000);
        send(10, 24'h7ABCDE, 24'h654321);
        send(25, 24'h7ABCDE, 24'h654321);
        send(3,  24'h100000, 24'hF00000);
        send(36, 24'h300000, 24'h080000);

        // reset in the middle of a computation
        send(40, 24'h400000, 24'h123456);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("midrst_out%0d", i), outs(i), 0);
            cmp($sformatf("midrst_stat%0d", i), stat(i), 0);
            if (sb[i].size() > 0) void'(sb[i].pop_back());
        end
        clear_model();
        t_acc   = -1000;
        t_last  = cyc;
        ovr_exp = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(3, 24'h400000, 24'hC00000);
        for (int n = 0; n < 5; n++) send(36, 24'h000000, 24'h000000);

        // random audio
        for (int n = 0; n < 500; n++)
            send($urandom_range(40, 36), 24'($urandom()), 24'($urandom()));

        for (int w = 0; w < 100; w++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            cmp($sformatf("pending%0d", i), sb[i].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
